// File: rtl/dmx8_evt.sv
// dmx8_evt: registered 1-to-8 event demultiplexer with per-channel pulse stretching
// Ports:
//   ck_i         clock, rising edge
//   rstn_i       synchronous active-low reset
//   en_i         event strobe, one event per cycle when high
//   s_i[2:0]     channel select for the event
//   clr_i[7:0]   per-channel synchronous cancel, wins over a same-channel event
//   z0_o..z7_o   stretched pulses, high for PW cycles per event (retrigger reloads)
//   busy_o       registered OR of the eight channel outputs
module dmx8_evt #(
    parameter int PW = 4
) (
    input  logic       ck_i,
    input  logic       rstn_i,
    input  logic       en_i,
    input  logic [2:0] s_i,
    input  logic [7:0] clr_i,
    output logic       z0_o,
    output logic       z1_o,
    output logic       z2_o,
    output logic       z3_o,
    output logic       z4_o,
    output logic       z5_o,
    output logic       z6_o,
    output logic       z7_o,
    output logic       busy_o
);
    if (PW < 1 || PW > 255) begin : g_bad_pw
        $error("dmx8_evt: PW must be in 1..255");
    end
    localparam logic [7:0] PW8 = 8'(PW);
    logic [7:0][7:0] cnt_q, cnt_d;
    logic [7:0]      z_q, z_d;
    logic            busy_q;
    always_comb begin
        cnt_d = '0;
        z_d   = '0;
        for (int n = 0; n < 8; n++) begin
            cnt_d[n] = clr_i[n]                  ? 8'd0 :
                       (en_i && s_i == 3'(n))    ? PW8 :
                       (cnt_q[n] != 8'd0)        ? cnt_q[n] - 8'd1 : 8'd0;
            z_d[n]   = cnt_d[n] != 8'd0;
        end
    end
    always_ff @(posedge ck_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            z_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            z_q    <= z_d;
            busy_q <= |z_d;
        end
    end
    assign {z7_o, z6_o, z5_o, z4_o, z3_o, z2_o, z1_o, z0_o} = z_q;
    assign busy_o = busy_q;
endmodule

// File: tb/tb_dmx8_evt.sv
// tb_dmx8_evt: directed self-checking bench for dmx8_evt built with PW = 1, 4, 8, 255
module tb_dmx8_evt;
    localparam int PWS [4] = '{1, 4, 8, 255};
    logic       clk = 1'b0;
    logic       rstn, en;
    logic [2:0] s;
    logic [7:0] clr;
    logic [8:0] o [4];
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmx8_evt #(.PW(PWS[g])) u_dut (
            .ck_i   (clk),
            .rstn_i (rstn),
            .en_i   (en),
            .s_i    (s),
            .clr_i  (clr),
            .z0_o   (o[g][0]),
            .z1_o   (o[g][1]),
            .z2_o   (o[g][2]),
            .z3_o   (o[g][3]),
            .z4_o   (o[g][4]),
            .z5_o   (o[g][5]),
            .z6_o   (o[g][6]),
            .z7_o   (o[g][7]),
            .busy_o (o[g][8])
        );
    end
    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {busy,z7..z0}=%09b expected %09b", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic r, input logic e, input logic [2:0] sel, input logic [7:0] c);
        rstn = r;
        en   = e;
        s    = sel;
        clr  = c;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        cyc(1'b0, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 1'b0, 3'd0, 8'h00);
        for (int g = 0; g < 4; g++) chk("reset", o[g], 9'h000);
    endtask
    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        s    = 3'd0;
        clr  = 8'h00;
        #2;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, 1'b0, 3'd0, 8'h00);
            for (int g = 0; g < 4; g++) chk("idle", o[g], 9'h000);
        end
        // single event on channel 5, PW=4: cycles 1..4 after the event edge
        do_reset();
        cyc(1'b1, 1'b1, 3'd5, 8'h00);
        for (int i = 0; i < 6; i++) begin
            chk("single_s5", o[1], (i < 4) ? 9'h120 : 9'h000);
            cyc(1'b1, 1'b0, 3'd0, 8'h00);
        end
        // retrigger on channel 2: events at edges 10 and 12
        do_reset();
        cyc(1'b1, 1'b1, 3'd2, 8'h00);
        for (int c = 11; c <= 17; c++) begin
            chk("retrigger_s2", o[1], (c <= 16) ? 9'h104 : 9'h000);
            cyc(1'b1, c == 12, 3'd2, 8'h00);
        end
        // event on 3 at edge 10, event on 6 with CLR[3] at edge 12
        do_reset();
        cyc(1'b1, 1'b1, 3'd3, 8'h00);
        for (int c = 11; c <= 17; c++) begin
            chk("clr_s3_evt_s6", o[1], (c <= 12) ? 9'h108 : (c <= 16) ? 9'h140 : 9'h000);
            cyc(1'b1, c == 12, 3'd6, (c == 12) ? 8'h08 : 8'h00);
        end
        // CLR wins over a simultaneous event on the same channel
        cyc(1'b1, 1'b1, 3'd1, 8'h02);
        chk("clr_beats_evt", o[1], 9'h000);
        cyc(1'b1, 1'b0, 3'd0, 8'h00);
        chk("clr_beats_evt_next", o[1], 9'h000);
        // PW=1: consecutive events on channel 0 at edges 5,6,7
        do_reset();
        cyc(1'b1, 1'b1, 3'd0, 8'h00);
        for (int c = 6; c <= 9; c++) begin
            chk("pw1_s0", o[0], (c <= 8) ? 9'h101 : 9'h000);
            cyc(1'b1, c <= 7, 3'd0, 8'h00);
        end
        // PW=255: one event on channel 7 gives exactly 255 high cycles
        do_reset();
        cyc(1'b1, 1'b1, 3'd7, 8'h00);
        for (int c = 1; c <= 257; c++) begin
            chk("pw255_s7", o[3], (c <= 255) ? 9'h180 : 9'h000);
            cyc(1'b1, 1'b0, 3'd0, 8'h00);
        end
        // PW=8: reset at edge 13 truncates the channel 4 pulse
        do_reset();
        cyc(1'b1, 1'b1, 3'd4, 8'h00);
        for (int c = 11; c <= 13; c++) begin
            chk("pw8_s4_active", o[2], 9'h110);
            cyc(c != 13, 1'b0, 3'd0, 8'h00);
        end
        chk("pw8_s4_reset", o[2], 9'h000);
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, 1'b0, 3'd0, 8'h00);
            chk("pw8_after_reset", o[2], 9'h000);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmx8_evt.md
# dmx8_evt

Registered 1-to-8 event demultiplexer with per-channel pulse stretching. An encoded event (3-bit channel select plus strobe) is decoded into one of eight output lines, each held high for a programmable number of cycles. It is the fan-out counterpart of the 8-input OR macro: its Z0..Z7 outputs drive OR8 inputs directly, and BUSY equals the OR8 result of those same lines, registered.

## Interface
- PW, 4, pulse width in clock cycles per event; legal range 1..255, held in an 8-bit counter per channel.
- CK  input  1  clock; all state updates on the rising edge.
- RSTN  input  1  reset, synchronous, active-low; takes effect on the CK edge where RSTN=0.
- EN  input  1  event strobe; sampled every CK edge; one event per cycle when high.
- S  input  3  channel select for the event; S=n targets Zn; ignored when EN=0.
- CLR  input  8  per-channel synchronous cancel; bit n=1 forces channel n idle.
- Z0..Z7  output  1 each  stretched event pulses, registered.
- BUSY  output  1  registered OR of the eight channel-active states.

## Operation
- Per channel n: 8-bit down-counter CNTn. Zn = (CNTn != 0), driven from a flop, no combinational path from inputs.
- Two states per channel:
  - IDLE: CNTn = 0, Zn = 0.
  - ACTIVE: CNTn in 1..PW, Zn = 1.
- Event on channel n (EN=1, S=n, CLR[n]=0): CNTn loads PW. From IDLE the channel enters ACTIVE. From ACTIVE the channel retriggers, meaning the counter reloads to PW (it does not add to the remaining count).
- No event and CLR[n]=0 in ACTIVE: CNTn decrements by 1 each cycle. Reaching 0 returns the channel to IDLE.
- CLR[n]=1: CNTn goes to 0 on that edge regardless of state. CLR takes priority over a simultaneous event on the same channel, and that event is dropped.
- Only the channel addressed by S is affected by an event. The other seven channels continue counting independently.
- BUSY = OR over n of the next-state (CNTn != 0). It is registered alongside Zn, so BUSY matches the OR of Z0..Z7 on every cycle.
- PW is outside 1..255: elaboration error. Synthesis must not accept it.
- Reset (RSTN=0 at an edge): all CNTn = 0, Z0..Z7 = 0, BUSY = 0. Reset overrides EN and CLR. Reset in the middle of a pulse truncates it at that edge, and nothing resumes after reset is released.

## Timing
- Reset values: Z0..Z7 = 0, BUSY = 0.
- Latency: an event sampled at edge k makes Zn high after edge k, for cycles k+1 through k+PW (exactly PW cycles). Zn falls after edge k+PW.
- Retrigger: an event at edge j while ACTIVE keeps Zn high through cycle j+PW. There is no low glitch between the two pulses.
- Back-to-back events on different channels at edges k and k+1 give overlapping pulses, offset by one cycle.
- PW=1: each event produces a single-cycle pulse. Events on consecutive edges to the same channel hold Zn continuously high.
- CLR at edge k: Zn is low from cycle k+1.
- BUSY has the same latency as Zn: high from cycle k+1 after the first event. It falls on the same edge as the last active Z falls.
- No handshake: every EN=1 cycle is consumed. The block never stalls or back-pressures.

## Test plan
- Reset then idle: RSTN=0 for 2 cycles, then 1, with EN=0 for 20 cycles -> Z0..Z7 = 0 and BUSY = 0 throughout.
- Single event, PW=4: EN=1, S=5 at edge 10 -> Z5 high for cycles 11..14 and low from 15; all other Z stay 0; BUSY high for 11..14.
- Retrigger, PW=4: S=2 events at edges 10 and 12 -> Z2 high continuously for cycles 11..16 and low at 17.
- Simultaneous events and CLR: event S=3 at edge 10, then at edge 12 an event on S=6 together with CLR=8'h08 -> Z3 high for cycles 11..12 and low from 13; Z6 high for 13..16. Separately, an event on S=1 together with CLR[1]=1 at the same edge -> Z1 stays 0.
- PW=1 and PW=255 builds: with PW=1, events on S=0 at edges 5,6,7 -> Z0 high for cycles 6..8. With PW=255, one event on S=7 at edge 0 -> Z7 high for exactly 255 cycles (1..255).
- Reset mid-pulse, PW=8: event S=4 at edge 10, then RSTN=0 at edge 13 -> Z4 and BUSY low from cycle 14; after release, Z4 stays low with no further events.
